// File: rtl/player_pkg.sv
// Shared codes for the player: facing direction and held/activity state.
// Used by player_controller and by the sprite renderer (player_blob).
package player_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  // Item codes double as tile object codes; 0 on a tile means empty.
  typedef enum logic [3:0] {
    ST_NOTHING       = 4'd0,
    ST_CHOPPING      = 4'd1,
    ST_ONION_WHOLE   = 4'd2,
    ST_ONION_CHOPPED = 4'd3,
    ST_POT_EMPTY     = 4'd4,
    ST_POT_RAW       = 4'd5,
    ST_POT_COOKED    = 4'd6,
    ST_BOWL_EMPTY    = 4'd7,
    ST_BOWL_FULL     = 4'd8,
    ST_EXT_OFF       = 4'd9,
    ST_EXT_ON        = 4'd10
  } pstate_t;

  localparam int SPRITE_SZ = 32;

  // True for codes that name a carryable item (everything but NOTHING/CHOPPING).
  function automatic logic is_item(input logic [3:0] code);
    return (code >= 4'd2) && (code <= 4'd10);
  endfunction

endpackage

// File: rtl/chop_timer.sv
// Counts frames of an ongoing chop. done is combinational so the owner can
// register it together with its state change in the same cycle.
module chop_timer
  import player_pkg::*;
#(
  parameter int CHOP_FRAMES = 120
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_frame,
  input  logic i_abort,
  output logic o_done
);

  localparam int CW = $clog2(CHOP_FRAMES + 1);

  logic          r_active;
  logic [CW-1:0] r_count;

  // Abort beats completion when both land on the same frame.
  assign o_done = r_active && i_frame && !i_abort &&
                  (r_count == CW'(CHOP_FRAMES - 1));

  // Frame counter: cleared on start, stepped per frame while active.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_count  <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_count  <= '0;
    end else if (i_abort || o_done) begin
      r_active <= 1'b0;
      r_count  <= '0;
    end else if (r_active && i_frame) begin
      r_count  <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/player_controller.sv
// Player movement, item grab/place, chopping and extinguisher control.
// Everything is computed combinationally and registered once, so each
// response appears the cycle after its input.
module player_controller
  import player_pkg::*;
#(
  parameter int START_X     = 64,
  parameter int START_Y     = 64,
  parameter int X_MIN       = 32,
  parameter int X_MAX       = 992,
  parameter int Y_MIN       = 32,
  parameter int Y_MAX       = 736,
  parameter int STEP        = 4,
  parameter int CHOP_FRAMES = 120
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        frame_in,
  input  logic        left_in,
  input  logic        right_in,
  input  logic        up_in,
  input  logic        down_in,
  input  logic        grab_in,
  input  logic        chop_in,
  input  logic [3:0]  front_obj_in,
  input  logic        front_is_counter_in,
  input  logic        front_is_board_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic [1:0]  player_direction_out,
  output logic [3:0]  player_state_out,
  output logic        pickup_out,
  output logic        place_out,
  output logic [3:0]  place_obj_out,
  output logic        chop_done_out
);

  localparam logic [10:0] LX_MIN = 11'(X_MIN);
  localparam logic [10:0] LX_HI  = 11'(X_MAX - SPRITE_SZ);
  localparam logic [9:0]  LY_MIN = 10'(Y_MIN);
  localparam logic [9:0]  LY_HI  = 10'(Y_MAX - SPRITE_SZ);

  logic [10:0] r_x;
  logic [9:0]  r_y;
  dir_t        r_dir;
  pstate_t     r_state;
  logic        r_pickup;
  logic        r_place;
  logic [3:0]  r_place_obj;
  logic        r_chop_done;
  logic        r_grab_d;

  logic [10:0] w_x_nxt;
  logic [9:0]  w_y_nxt;
  dir_t        w_dir_nxt;
  pstate_t     w_state_nxt;
  logic        w_pickup_nxt;
  logic        w_place_nxt;
  logic [3:0]  w_place_obj_nxt;
  logic        w_grab_acted;

  logic w_grab_edge;
  logic w_any_dir;
  logic w_chopping;
  logic w_chop_abort;
  logic w_chop_start;
  logic w_timer_done;

  assign w_grab_edge  = grab_in && !r_grab_d;
  assign w_any_dir    = left_in || right_in || up_in || down_in;
  assign w_chopping   = (r_state == ST_CHOPPING);
  assign w_chop_abort = w_chopping &&
                        (!chop_in || w_any_dir || !front_is_board_in ||
                         (front_obj_in != ST_ONION_WHOLE));
  // A grab edge in the same cycle wins; the grab picks the onion up instead.
  assign w_chop_start = (r_state == ST_NOTHING) && chop_in && !w_grab_edge &&
                        front_is_board_in && (front_obj_in == ST_ONION_WHOLE);

  chop_timer #(
    .CHOP_FRAMES (CHOP_FRAMES)
  ) u_chop_timer (
    .clk     (pixel_clk_in),
    .rst     (rst_in),
    .i_start (w_chop_start),
    .i_frame (frame_in),
    .i_abort (w_chop_abort),
    .o_done  (w_timer_done)
  );

  // Movement: one step per frame, left>right>up>down, clamped to the play area.
  always_comb begin
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    w_dir_nxt = r_dir;
    if (frame_in && !w_chopping) begin
      if (left_in) begin
        w_dir_nxt = DIR_LEFT;
        w_x_nxt   = ({1'b0, r_x} >= 12'(X_MIN + STEP)) ? r_x - 11'(STEP) : LX_MIN;
      end else if (right_in) begin
        w_dir_nxt = DIR_RIGHT;
        w_x_nxt   = ({1'b0, r_x} + 12'(STEP) <= {1'b0, LX_HI}) ? r_x + 11'(STEP) : LX_HI;
      end else if (up_in) begin
        w_dir_nxt = DIR_UP;
        w_y_nxt   = ({1'b0, r_y} >= 11'(Y_MIN + STEP)) ? r_y - 10'(STEP) : LY_MIN;
      end else if (down_in) begin
        w_dir_nxt = DIR_DOWN;
        w_y_nxt   = ({1'b0, r_y} + 11'(STEP) <= {1'b0, LY_HI}) ? r_y + 10'(STEP) : LY_HI;
      end
    end
  end

  // Held-state machine: chop progress, grab rules, then extinguisher spray.
  always_comb begin
    w_state_nxt     = r_state;
    w_pickup_nxt    = 1'b0;
    w_place_nxt     = 1'b0;
    w_place_obj_nxt = 4'd0;
    w_grab_acted    = 1'b0;
    if (w_chopping) begin
      if (w_chop_abort || w_timer_done) w_state_nxt = ST_NOTHING;
    end else begin
      if (w_grab_edge) begin
        w_grab_acted = 1'b1;
        if (r_state == ST_NOTHING && is_item(front_obj_in)) begin
          w_pickup_nxt = 1'b1;
          w_state_nxt  = pstate_t'(front_obj_in);
        end else if (r_state == ST_ONION_CHOPPED && front_obj_in == ST_POT_EMPTY) begin
          w_place_nxt     = 1'b1;
          w_place_obj_nxt = ST_POT_RAW;
          w_state_nxt     = ST_NOTHING;
        end else if (r_state == ST_BOWL_EMPTY && front_obj_in == ST_POT_COOKED) begin
          w_place_nxt     = 1'b1;
          w_place_obj_nxt = ST_POT_EMPTY;
          w_state_nxt     = ST_BOWL_FULL;
        end else if (r_state != ST_NOTHING && front_obj_in == 4'd0 && front_is_counter_in) begin
          w_place_nxt     = 1'b1;
          w_place_obj_nxt = r_state;
          w_state_nxt     = ST_NOTHING;
        end else begin
          w_grab_acted = 1'b0;
        end
      end
      if (!w_grab_acted) begin
        if (w_chop_start)                          w_state_nxt = ST_CHOPPING;
        else if (r_state == ST_EXT_OFF && chop_in)  w_state_nxt = ST_EXT_ON;
        else if (r_state == ST_EXT_ON && !chop_in)  w_state_nxt = ST_EXT_OFF;
      end
    end
  end

  // Register every output plus the grab edge history.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_x         <= 11'(START_X);
      r_y         <= 10'(START_Y);
      r_dir       <= DIR_DOWN;
      r_state     <= ST_NOTHING;
      r_pickup    <= 1'b0;
      r_place     <= 1'b0;
      r_place_obj <= 4'd0;
      r_chop_done <= 1'b0;
      r_grab_d    <= 1'b0;
    end else begin
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_dir       <= w_dir_nxt;
      r_state     <= w_state_nxt;
      r_pickup    <= w_pickup_nxt;
      r_place     <= w_place_nxt;
      r_place_obj <= w_place_obj_nxt;
      r_chop_done <= w_timer_done;
      r_grab_d    <= grab_in;
    end
  end

  assign x_out                = r_x;
  assign y_out                = r_y;
  assign player_direction_out = r_dir;
  assign player_state_out     = r_state;
  assign pickup_out           = r_pickup;
  assign place_out            = r_place;
  assign place_obj_out        = r_place_obj;
  assign chop_done_out        = r_chop_done;

endmodule

// File: tb/tb_player_controller.sv
// Directed bench for player_controller (CHOP_FRAMES=4, other params default).
module tb_player_controller;

  logic        clk = 1'b0;
  logic        rst, frame, left, right, up, down, grab, chop;
  logic [3:0]  front_obj;
  logic        is_counter, is_board;
  logic [10:0] x;
  logic [9:0]  y;
  logic [1:0]  dir;
  logic [3:0]  st;
  logic        pickup, place, chop_done;
  logic [3:0]  place_obj;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  player_controller #(.CHOP_FRAMES(4)) dut (
    .pixel_clk_in        (clk),
    .rst_in              (rst),
    .frame_in            (frame),
    .left_in             (left),
    .right_in            (right),
    .up_in               (up),
    .down_in             (down),
    .grab_in             (grab),
    .chop_in             (chop),
    .front_obj_in        (front_obj),
    .front_is_counter_in (is_counter),
    .front_is_board_in   (is_board),
    .x_out               (x),
    .y_out               (y),
    .player_direction_out(dir),
    .player_state_out    (st),
    .pickup_out          (pickup),
    .place_out           (place),
    .place_obj_out       (place_obj),
    .chop_done_out       (chop_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame();
    frame = 1'b1; tick();
    frame = 1'b0; tick();
  endtask

  task automatic clear_inputs();
    frame = 0; left = 0; right = 0; up = 0; down = 0; grab = 0; chop = 0;
    front_obj = 4'd0; is_counter = 0; is_board = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (x !== 11'd64 || y !== 10'd64 || dir !== 2'd3 || st !== 4'd0) begin
      errors++;
      $display("FAIL reset_pos: x=%0d y=%0d dir=%0d st=%0d, want 64 64 3 0", x, y, dir, st);
    end
    checks++;
    if (pickup !== 0 || place !== 0 || chop_done !== 0 || place_obj !== 4'd0) begin
      errors++;
      $display("FAIL reset_pulses: pickup=%b place=%b done=%b obj=%0d, want 0 0 0 0",
               pickup, place, chop_done, place_obj);
    end
  endtask

  task automatic test_move();
    right = 1;
    repeat (3) tick();
    checks++;
    if (x !== 11'd64) begin errors++; $display("FAIL move_no_frame: x=%0d want 64", x); end
    do_frame();
    checks++;
    if (x !== 11'd68 || dir !== 2'd1) begin
      errors++; $display("FAIL move_first: x=%0d dir=%0d want 68 1", x, dir);
    end
    repeat (299) do_frame();
    checks++;
    if (x !== 11'd960 || dir !== 2'd1 || y !== 10'd64) begin
      errors++; $display("FAIL move_right_sat: x=%0d dir=%0d y=%0d want 960 1 64", x, dir, y);
    end
    left = 1;
    do_frame();
    checks++;
    if (x !== 11'd956 || dir !== 2'd0) begin
      errors++; $display("FAIL move_priority_lr: x=%0d dir=%0d want 956 0", x, dir);
    end
    right = 0;
    repeat (300) do_frame();
    checks++;
    if (x !== 11'd32 || dir !== 2'd0) begin
      errors++; $display("FAIL move_left_sat: x=%0d dir=%0d want 32 0", x, dir);
    end
    left = 0; up = 1; down = 1;
    repeat (20) do_frame();
    checks++;
    if (y !== 10'd32 || dir !== 2'd2) begin
      errors++; $display("FAIL move_up_sat: y=%0d dir=%0d want 32 2", y, dir);
    end
    up = 0;
    repeat (300) do_frame();
    checks++;
    if (y !== 10'd704 || dir !== 2'd3 || x !== 11'd32) begin
      errors++; $display("FAIL move_down_sat: y=%0d dir=%0d x=%0d want 704 3 32", y, dir, x);
    end
    down = 0;
    left = 1;
    do_frame();
    checks++;
    if (x !== 11'd32 || dir !== 2'd0) begin
      errors++; $display("FAIL move_clamp_dir: x=%0d dir=%0d want 32 0", x, dir);
    end
    left = 0;
  endtask

  task automatic test_grab_once();
    logic bad;
    front_obj = 4'd2; grab = 1;
    tick();
    checks++;
    if (pickup !== 1 || st !== 4'd2) begin
      errors++; $display("FAIL grab_pickup: pickup=%b st=%0d want 1 2", pickup, st);
    end
    bad = 0;
    repeat (10) begin
      tick();
      if (pickup !== 0 || place !== 0 || st !== 4'd2) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL grab_held: extra action, pickup=%b st=%0d want 0 2", pickup, st); end
    grab = 0; tick();
    front_obj = 4'd0; is_counter = 1; grab = 1;
    tick();
    checks++;
    if (place !== 1 || place_obj !== 4'd2 || st !== 4'd0) begin
      errors++; $display("FAIL place_counter: place=%b obj=%0d st=%0d want 1 2 0", place, place_obj, st);
    end
    tick();
    checks++;
    if (place !== 0) begin errors++; $display("FAIL place_pulse: place=%b want 0", place); end
    grab = 0; is_counter = 0; tick();
  endtask

  task automatic test_pot_and_bowl();
    front_obj = 4'd3; grab = 1; tick(); grab = 0; tick();
    front_obj = 4'd4; grab = 1; tick();
    checks++;
    if (place !== 1 || place_obj !== 4'd5 || st !== 4'd0) begin
      errors++; $display("FAIL pot_fill: place=%b obj=%0d st=%0d want 1 5 0", place, place_obj, st);
    end
    grab = 0; tick();
    front_obj = 4'd7; grab = 1; tick(); grab = 0; tick();
    front_obj = 4'd6; grab = 1; tick();
    checks++;
    if (place !== 1 || place_obj !== 4'd4 || st !== 4'd8 || pickup !== 0) begin
      errors++; $display("FAIL bowl_fill: place=%b obj=%0d st=%0d want 1 4 8", place, place_obj, st);
    end
    grab = 0; tick();
    front_obj = 4'd5; grab = 1; tick();
    checks++;
    if (place !== 0 || pickup !== 0 || st !== 4'd8) begin
      errors++; $display("FAIL grab_ignored: place=%b pickup=%b st=%0d want 0 0 8", place, pickup, st);
    end
    grab = 0; tick();
    front_obj = 4'd0; is_counter = 1; grab = 1; tick();
    checks++;
    if (place !== 1 || place_obj !== 4'd8 || st !== 4'd0) begin
      errors++; $display("FAIL bowl_drop: place=%b obj=%0d st=%0d want 1 8 0", place, place_obj, st);
    end
    grab = 0; is_counter = 0; tick();
  endtask

  task automatic test_chop();
    logic bad;
    front_obj = 4'd2; is_board = 1; chop = 1;
    tick();
    checks++;
    if (st !== 4'd1) begin errors++; $display("FAIL chop_start: st=%0d want 1", st); end
    bad = 0;
    repeat (3) begin
      do_frame();
      if (st !== 4'd1 || chop_done !== 0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL chop_early: st=%0d done=%b want 1 0", st, chop_done); end
    frame = 1; tick();
    checks++;
    if (chop_done !== 1 || st !== 4'd0) begin
      errors++; $display("FAIL chop_done: done=%b st=%0d want 1 0", chop_done, st);
    end
    frame = 0; chop = 0; tick();
    checks++;
    if (chop_done !== 0 || st !== 4'd0) begin
      errors++; $display("FAIL chop_done_pulse: done=%b st=%0d want 0 0", chop_done, st);
    end
    chop = 1; tick();
    do_frame(); do_frame();
    chop = 0; tick();
    checks++;
    if (st !== 4'd0 || chop_done !== 0) begin
      errors++; $display("FAIL chop_abort: st=%0d done=%b want 0 0", st, chop_done);
    end
    bad = 0;
    repeat (3) begin
      frame = 1; tick(); if (chop_done !== 0) bad = 1;
      frame = 0; tick(); if (chop_done !== 0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL chop_abort_done: done=%b want 0", chop_done); end
  endtask

  task automatic test_grab_priority();
    front_obj = 4'd2; is_board = 1; chop = 1; grab = 1;
    tick();
    checks++;
    if (pickup !== 1 || st !== 4'd2) begin
      errors++; $display("FAIL grab_vs_chop: pickup=%b st=%0d want 1 2", pickup, st);
    end
    chop = 0; grab = 0; tick();
    front_obj = 4'd0; is_board = 0; is_counter = 1; grab = 1; tick();
    grab = 0; is_counter = 0; tick();
    checks++;
    if (st !== 4'd0) begin errors++; $display("FAIL grab_vs_chop_drop: st=%0d want 0", st); end
  endtask

  task automatic test_ext();
    front_obj = 4'd9; grab = 1; tick(); grab = 0; front_obj = 4'd0; tick();
    chop = 1; tick();
    checks++;
    if (st !== 4'd10) begin errors++; $display("FAIL ext_on: st=%0d want 10", st); end
    chop = 0; tick();
    checks++;
    if (st !== 4'd9) begin errors++; $display("FAIL ext_off: st=%0d want 9", st); end
    is_counter = 1; grab = 1; tick();
    checks++;
    if (place !== 1 || place_obj !== 4'd9 || st !== 4'd0) begin
      errors++; $display("FAIL ext_drop: place=%b obj=%0d st=%0d want 1 9 0", place, place_obj, st);
    end
    grab = 0; is_counter = 0; tick();
  endtask

  task automatic test_frame_with_grab();
    apply_reset();
    right = 1; frame = 1; front_obj = 4'd2; grab = 1;
    tick();
    checks++;
    if (x !== 11'd68 || pickup !== 1 || st !== 4'd2) begin
      errors++; $display("FAIL frame_with_grab: x=%0d pickup=%b st=%0d want 68 1 2", x, pickup, st);
    end
    clear_inputs(); tick();
  endtask

  task automatic test_reset_mid_chop();
    apply_reset();
    front_obj = 4'd2; is_board = 1; chop = 1; tick();
    repeat (3) do_frame();
    frame = 1; rst = 1; tick();
    checks++;
    if (st !== 4'd0 || chop_done !== 0) begin
      errors++; $display("FAIL rst_mid_chop: st=%0d done=%b want 0 0", st, chop_done);
    end
    rst = 0; frame = 0; chop = 0; tick();
    checks++;
    if (chop_done !== 0 || st !== 4'd0 || x !== 11'd64) begin
      errors++; $display("FAIL rst_mid_chop_after: done=%b st=%0d x=%0d want 0 0 64", chop_done, st, x);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_move();
    test_grab_once();
    test_pot_and_bowl();
    test_chop();
    test_grab_priority();
    test_ext();
    test_frame_with_grab();
    test_reset_mid_chop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
